dac_spi_out: RTL
================

// Module: dac_spi_out
// PURPOSE
//  Downstream output stage of top_vector_display. Serialises the beam coordinates xch/ych onto
//  a dual-channel 12-bit SPI DAC pair (DAC121S101-style: shared SCLK/SYNC, one data line per channel).
//  Each frame samples the current coordinates, which then drive the oscilloscope X/Y inputs.
//  Frames free-run while en=1.
// PARAMETERS
//  IN_WIDTH    8   width of x_in/y_in (== OUT_WIDTH of the display path)
//  DAC_WIDTH   12  DAC resolution; requires IN_WIDTH <= DAC_WIDTH
//  CLK_DIV     4   clk cycles per SCLK half-period; >= 1
//  GAP_CYCLES  2   clk cycles sync_n stays high between frames; >= 1
// PORTS
//  clk         in   1          system clock (clk_slow domain)
//  rst         in   1          asynchronous, active-low reset
//  en          in   1          1 = start a new frame whenever idle
//  x_in        in   IN_WIDTH   X coordinate (from x_ch)
//  y_in        in   IN_WIDTH   Y coordinate (from y_ch)
//  sclk        out  1          SPI clock, idles high, DAC samples on falling edge
//  sync_n      out  1          frame sync, active low
//  sdata_x     out  1          serial data to X DAC, MSB first
//  sdata_y     out  1          serial data to Y DAC, MSB first
//  busy        out  1          1 while in SHIFT or GAP
//  frame_done  out  1          1-cycle pulse at end of each frame
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: sclk=1, sync_n=1, sdata_x=0, sdata_y=0, busy=0, frame_done=0. State is IDLE.
//  - Word is 16 bits: {2'b00 don't-care, 2'b00 PD=normal, data}.
//    data = {in, (DAC_WIDTH-IN_WIDTH) zeros}, so 8'hFF -> 12'hFF0 and 8'h00 -> 12'h000.
//  - FSM states IDLE -> SHIFT -> GAP -> IDLE.
//  - IDLE:
//    - sync_n=1, sclk=1.
//    - On a clk edge with en=1: capture x_in/y_in into the shift regs, bit_cnt=15, div_cnt=0, go to SHIFT.
//    - Next cycle: sync_n=0, busy=1, and sdata_x/y = MSB (bit 15).
//  - SHIFT:
//    - Each bit lasts 2*CLK_DIV cycles.
//    - sclk=1 for div_cnt 0..CLK_DIV-1 and sclk=0 for CLK_DIV..2*CLK_DIV-1, giving one falling edge per bit mid-period.
//    - At the end of a bit period: if bit_cnt==0, go to GAP; otherwise shift left and decrement bit_cnt.
//    - Data changes only on bit boundaries, while sclk=1.
//    - Exactly 16 falling edges per frame.
//    - sync_n stays low for 32*CLK_DIV cycles.
//  - GAP:
//    - sync_n=1, sclk=1, sdata=0, busy=1 for GAP_CYCLES cycles.
//    - On the last GAP cycle, go to IDLE. frame_done=1 and busy=0 on the first IDLE cycle.
//  - Frame period with en held high: 1 + 32*CLK_DIV + GAP_CYCLES cycles (131 at defaults).
//  - x_in/y_in changing mid-frame has no effect; the values are sampled only at IDLE->SHIFT.
//  - en falling mid-frame: the current frame completes normally; no new frame starts.
//  - Asynchronous reset mid-frame: outputs go to reset values immediately and the frame is aborted.
//    The DAC discards frames with fewer than 16 falling edges.
//  - Counters: div_cnt is $clog2(2*CLK_DIV) bits and wraps at 2*CLK_DIV-1. bit_cnt is 4 bits.
//    The gap counter is $clog2(GAP_CYCLES+1) bits.
// TESTING
//  1. Reset assertion with en=1 -> all outputs at reset values. No sclk toggles while rst=0.
//  2. en pulse, x_in=8'hA5, y_in=8'h3C ->
//     - sdata_x sampled on sclk falls = 16'h0A50;
//     - sdata_y = 16'h03C0;
//     - 16 falls; sync_n low for 128 cycles;
//     - one frame_done pulse.
//  3. en held high 5 frames, defaults -> frame_done pulses exactly 131 cycles apart; busy low 1 cycle between frames.
//  4. Change x_in 8'h00->8'hFF at bit 8 of a frame -> that frame shifts 12'h000. The next frame shifts 12'hFF0.
//  5. en dropped at bit 3 -> frame completes (16 falls, frame_done), then stays IDLE.
//     Async rst at bit 5 -> sync_n=1 and sclk=1 within the same cycle.
//  6. CLK_DIV=1, GAP_CYCLES=1 -> period 34 cycles, sclk toggles every cycle in SHIFT, data still 16'h0A50 for 8'hA5.

Source files
------------

// File: rtl/dac_spi_out_if.sv
// Coordinate input and dual-DAC SPI output bundle for dac_spi_out.
// master = coordinate source / DAC side, slave = dac_spi_out.
interface dac_spi_out_if #(
  parameter int IN_WIDTH = 8
);
  logic                en;
  logic [IN_WIDTH-1:0] x_in;
  logic [IN_WIDTH-1:0] y_in;
  logic                sclk;
  logic                sync_n;
  logic                sdata_x;
  logic                sdata_y;
  logic                busy;
  logic                frame_done;

  modport master (
    output en, x_in, y_in,
    input  sclk, sync_n, sdata_x, sdata_y,
    input  busy, frame_done
  );

  modport slave (
    input  en, x_in, y_in,
    output sclk, sync_n, sdata_x, sdata_y,
    output busy, frame_done
  );
endinterface

// File: rtl/dac_spi_out.sv
// Serialises X/Y beam coordinates onto a pair of 16-bit-frame SPI DACs
// sharing SCLK/SYNC; frames free-run while en is high.
module dac_spi_out #(
  parameter int IN_WIDTH   = 8,
  parameter int DAC_WIDTH  = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  dac_spi_out_if.slave   bus
);

  localparam int DIVW = $clog2(2*CLK_DIV);
  localparam int GAPW = $clog2(GAP_CYCLES+1);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2*CLK_DIV-1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_CYCLES-1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  // Upper nibble is don't-care + power-down=normal, input left-aligned.
  function automatic logic [15:0] to_word(
    input logic [IN_WIDTH-1:0] v
  );
    return 16'(v) << (DAC_WIDTH-IN_WIDTH);
  endfunction

  state_e          state_q, state_d;
  logic [15:0]     sh_x_q, sh_x_d;
  logic [15:0]     sh_y_q, sh_y_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [GAPW-1:0] gap_cnt_q, gap_cnt_d;
  logic            sclk_q, sclk_d;
  logic            sync_n_q, sync_n_d;
  logic            sdata_x_q, sdata_x_d;
  logic            sdata_y_q, sdata_y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            in_shift;

  always_comb begin
    state_d   = state_q;
    sh_x_d    = sh_x_q;
    sh_y_d    = sh_y_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = SHIFT;
          sh_x_d    = to_word(bus.x_in);
          sh_y_d    = to_word(bus.y_in);
          bit_cnt_d = 4'd15;
          div_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 4'd0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            sh_x_d    = {sh_x_q[14:0], 1'b0};
            sh_y_d    = {sh_y_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up
    // with the state they describe.
    in_shift  = (state_d == SHIFT);
    sclk_d    = !in_shift || (div_cnt_d < DIV_HALF);
    sync_n_d  = !in_shift;
    sdata_x_d = in_shift && sh_x_d[15];
    sdata_y_d = in_shift && sh_y_d[15];
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == GAP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      sdata_x_q <= 1'b0;
      sdata_y_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      sdata_x_q <= sdata_x_d;
      sdata_y_q <= sdata_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.sync_n     = sync_n_q;
  assign bus.sdata_x    = sdata_x_q;
  assign bus.sdata_y    = sdata_y_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
